axis_input_framer: RTL and testbench



---
 rtl/axis_input_framer.sv | 139 +++++++++++++
 tb/tb_axis_input_framer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_input_framer.sv
// AXI-Stream ingress framer: FIFO-buffers samples and releases FRAME_LEN of them per frame to Layer 1.
// Optional framing check (s_in_last / frame_err) built when FRAME_CHECK_EN is defined.
module axis_input_framer #(
   parameter int DATA_WIDTH = 16,
   parameter int FRAME_LEN  = 784,
   parameter int FIFO_DEPTH = 64,
   parameter int DEPTH_LOG2 = 6
) (
   input  logic                  s_axi_aclk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] s_in_data,
   input  logic                  s_in_valid,
   output logic                  s_in_ready,
   output logic [DATA_WIDTH-1:0] x_in,
   output logic                  x_valid,
   input  logic                  layer_done,
   output logic                  busy,
   output logic [DEPTH_LOG2:0]   fifo_level,
`ifdef FRAME_CHECK_EN
   input  logic                  s_in_last,
   output logic                  frame_err,
`endif
   output logic [15:0]           frame_count
);

   localparam int                  CNT_W    = $clog2(FRAME_LEN + 1);
   localparam int                  LVL_W    = DEPTH_LOG2 + 1;
   localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(FRAME_LEN);
   localparam logic [LVL_W-1:0]    FULL_LVL = LVL_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, STREAM, WAIT_DONE} state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
   logic [15:0]             fc_q, fc_d;
   logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
   logic [DEPTH_LOG2-1:0]   wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]        level_q;
   logic [DATA_WIDTH-1:0]   x_in_q;
   logic                    x_valid_q;
   logic                    push, pop;

   assign s_in_ready  = !reset && (level_q != FULL_LVL);
   assign push        = s_in_valid && s_in_ready;
   assign pop         = (state_q != WAIT_DONE) && (level_q != '0);
   assign x_in        = x_in_q;
   assign x_valid     = x_valid_q;
   assign fifo_level  = level_q;
   assign frame_count = fc_q;
   assign busy        = (state_q != IDLE) || (level_q != '0);

   always_ff @(posedge s_axi_aclk) begin
      if (push) mem_q[wr_ptr_q] <= s_in_data;
   end

   // Pointers wrap naturally at DEPTH_LOG2 bits; the extra level bit distinguishes full from empty.
   always_ff @(posedge s_axi_aclk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   always_ff @(posedge s_axi_aclk) begin
      if (reset) begin
         x_in_q    <= '0;
         x_valid_q <= 1'b0;
      end else begin
         x_valid_q <= pop;
         if (pop) x_in_q <= mem_q[rd_ptr_q];
      end
   end

   always_ff @(posedge s_axi_aclk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         fc_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fc_q    <= fc_d;
      end
   end

   assign cnt_inc = cnt_q + 1'b1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fc_d    = fc_q;
      case (state_q)
         IDLE, STREAM: begin
            if (pop) begin
               cnt_d   = cnt_inc;
               state_d = (cnt_inc == LAST_CNT) ? WAIT_DONE : STREAM;
            end
         end
         WAIT_DONE: begin
            if (layer_done) begin
               state_d = IDLE;
               cnt_d   = '0;
               fc_d    = fc_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef FRAME_CHECK_EN
   logic [CNT_W-1:0] acc_cnt_q;
   logic             err_q;
   logic             last_pos;

   assign last_pos  = (acc_cnt_q == LAST_CNT - 1'b1);
   assign frame_err = err_q;

   // Accept-side position counter, independent of the drain side.
   always_ff @(posedge s_axi_aclk) begin
      if (reset) begin
         acc_cnt_q <= '0;
         err_q     <= 1'b0;
      end else if (push) begin
         acc_cnt_q <= last_pos ? '0 : acc_cnt_q + 1'b1;
         if (s_in_last != last_pos) err_q <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_axis_input_framer.sv
// Table-driven bench for axis_input_framer: DUT A (FRAME_LEN=4, depth 8) and DUT B (FRAME_LEN=16, depth 8).
module tb_axis_input_framer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   logic        rst_a = 1'b1, va = 1'b0, lda = 1'b0;
   logic [15:0] da = '0;
   logic        rdy_a, xv_a, busy_a;
   logic [15:0] xin_a, fc_a;
   logic [3:0]  lvl_a;
`ifdef FRAME_CHECK_EN
   logic        la = 1'b0;
   logic        err_a;
`endif

   logic        rst_b = 1'b1, vb = 1'b0, ldb = 1'b0;
   logic [15:0] db = '0;
   logic        rdy_b, xv_b, busy_b;
   logic [15:0] xin_b, fc_b;
   logic [3:0]  lvl_b;
`ifdef FRAME_CHECK_EN
   logic        err_b;
`endif

   axis_input_framer #(.DATA_WIDTH(16), .FRAME_LEN(4), .FIFO_DEPTH(8), .DEPTH_LOG2(3)) dut_a (
      .s_axi_aclk(clk), .reset(rst_a), .s_in_data(da), .s_in_valid(va), .s_in_ready(rdy_a),
      .x_in(xin_a), .x_valid(xv_a), .layer_done(lda), .busy(busy_a), .fifo_level(lvl_a),
`ifdef FRAME_CHECK_EN
      .s_in_last(la), .frame_err(err_a),
`endif
      .frame_count(fc_a));

   axis_input_framer #(.DATA_WIDTH(16), .FRAME_LEN(16), .FIFO_DEPTH(8), .DEPTH_LOG2(3)) dut_b (
      .s_axi_aclk(clk), .reset(rst_b), .s_in_data(db), .s_in_valid(vb), .s_in_ready(rdy_b),
      .x_in(xin_b), .x_valid(xv_b), .layer_done(ldb), .busy(busy_b), .fifo_level(lvl_b),
`ifdef FRAME_CHECK_EN
      .s_in_last(1'b0), .frame_err(err_b),
`endif
      .frame_count(fc_b));

   typedef struct {
      int rst, v, d, ld;
      int xv, xd, rdy, lvl, busy, fc;
   } vec_t;

   vec_t tbl[$];
   int   got_b[$];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add(input int rst, v, d, ld, xv, xd, rdy, lvl, busy, fc);
      vec_t r;
      r = '{rst, v, d, ld, xv, xd, rdy, lvl, busy, fc};
      tbl.push_back(r);
   endtask

   task automatic tick_b();
      @(posedge clk); #1;
      if (xv_b) got_b.push_back(int'(xin_b));
   endtask

   initial begin
      int k;
      int acc;

      //   rst v  d      ld | xv xd     rdy lvl busy fc
      add(1, 0, 'h00, 0,  0, 'h00, 0, 0, 0, 0);
      add(0, 1, 'h11, 0,  0, 'h00, 1, 1, 1, 0);
      add(0, 1, 'h22, 0,  1, 'h11, 1, 1, 1, 0);
      add(0, 1, 'h33, 0,  1, 'h22, 1, 1, 1, 0);
      add(0, 1, 'h44, 0,  1, 'h33, 1, 1, 1, 0);
      add(0, 0, 'h00, 0,  1, 'h44, 1, 0, 1, 0);
      add(0, 0, 'h00, 0,  0, 'h44, 1, 0, 1, 0);
      add(0, 0, 'h00, 1,  0, 'h44, 1, 0, 0, 1);
      add(0, 0, 'h00, 1,  0, 'h44, 1, 0, 0, 1);   // layer_done in IDLE
      add(0, 1, 'h55, 0,  0, 'h44, 1, 1, 1, 1);
      add(0, 0, 'h00, 1,  1, 'h55, 1, 0, 1, 1);
      add(0, 0, 'h00, 1,  0, 'h55, 1, 0, 1, 1);   // layer_done in STREAM
      add(0, 1, 'h66, 0,  0, 'h55, 1, 1, 1, 1);
      add(0, 0, 'h00, 0,  1, 'h66, 1, 0, 1, 1);
      add(0, 0, 'h00, 0,  0, 'h66, 1, 0, 1, 1);
      add(0, 0, 'h00, 0,  0, 'h66, 1, 0, 1, 1);
      add(0, 1, 'h77, 0,  0, 'h66, 1, 1, 1, 1);
      add(0, 0, 'h00, 0,  1, 'h77, 1, 0, 1, 1);
      add(0, 0, 'h00, 0,  0, 'h77, 1, 0, 1, 1);
      add(0, 0, 'h00, 0,  0, 'h77, 1, 0, 1, 1);
      add(0, 1, 'h88, 0,  0, 'h77, 1, 1, 1, 1);
      add(0, 0, 'h00, 0,  1, 'h88, 1, 0, 1, 1);
      add(0, 1, 'h99, 0,  0, 'h88, 1, 1, 1, 1);   // held in WAIT_DONE
      add(0, 1, 'h9A, 0,  0, 'h88, 1, 2, 1, 1);
      add(0, 1, 'h9B, 0,  0, 'h88, 1, 3, 1, 1);
      add(0, 1, 'h9C, 0,  0, 'h88, 1, 4, 1, 1);
      add(0, 0, 'h00, 1,  0, 'h88, 1, 4, 1, 2);
      add(0, 0, 'h00, 0,  1, 'h99, 1, 3, 1, 2);
      add(0, 0, 'h00, 0,  1, 'h9A, 1, 2, 1, 2);
      add(1, 0, 'h00, 0,  0, 'h00, 0, 0, 0, 0);   // reset mid-frame
      add(0, 0, 'h00, 0,  0, 'h00, 1, 0, 0, 0);
      add(0, 1, 'hB1, 0,  0, 'h00, 1, 1, 1, 0);
      add(0, 1, 'hB2, 0,  1, 'hB1, 1, 1, 1, 0);
      add(0, 1, 'hB3, 0,  1, 'hB2, 1, 1, 1, 0);
      add(0, 1, 'hB4, 0,  1, 'hB3, 1, 1, 1, 0);
      add(0, 0, 'h00, 0,  1, 'hB4, 1, 0, 1, 0);
      add(0, 0, 'h00, 1,  0, 'hB4, 1, 0, 0, 1);

      #1;
      for (int i = 0; i < tbl.size(); i++) begin
         rst_a = tbl[i].rst[0];
         va    = tbl[i].v[0];
         da    = tbl[i].d[15:0];
         lda   = tbl[i].ld[0];
         @(posedge clk); #1;
         chk($sformatf("row%0d x_valid", i),    int'(xv_a),   tbl[i].xv);
         chk($sformatf("row%0d x_in", i),       int'(xin_a),  tbl[i].xd);
         chk($sformatf("row%0d s_in_ready", i), int'(rdy_a),  tbl[i].rdy);
         chk($sformatf("row%0d fifo_level", i), int'(lvl_a),  tbl[i].lvl);
         chk($sformatf("row%0d busy", i),       int'(busy_a), tbl[i].busy);
         chk($sformatf("row%0d frame_count", i), int'(fc_a),  tbl[i].fc);
      end
      va = 1'b0; lda = 1'b0;

      // DUT B: backpressure while held in WAIT_DONE
      tick_b();
      rst_b = 1'b0;
      for (int i = 0; i < 16; i++) begin
         vb = 1'b1; db = 16'h100 + 16'(i);
         tick_b();
      end
      vb = 1'b0;
      tick_b(); tick_b();
      chk("B frame0 count", got_b.size(), 16);
      for (int i = 0; i < 16 && i < got_b.size(); i++)
         chk($sformatf("B frame0 data%0d", i), got_b[i], 'h100 + i);
      chk("B busy in WAIT_DONE", int'(busy_b), 1);

      k = 0; vb = 1'b1; db = 16'h200;
      for (int c = 0; c < 20 && k < 8; c++) begin
         acc = int'(rdy_b);
         tick_b();
         if (acc != 0) begin k++; db = 16'h200 + 16'(k); end
      end
      chk("B accepts before full", k, 8);
      chk("B ready when full", int'(rdy_b), 0);
      chk("B level when full", int'(lvl_b), 8);
      tick_b(); tick_b(); tick_b();
      chk("B level held", int'(lvl_b), 8);
      chk("B no forward in WAIT_DONE", got_b.size(), 16);

      ldb = 1'b1; tick_b(); ldb = 1'b0;
      chk("B frame_count", int'(fc_b), 1);
      for (int c = 0; c < 40; c++) begin
         acc = int'(rdy_b && vb);
         tick_b();
         if (acc != 0) begin
            k++;
            if (k == 10) vb = 1'b0;
            else db = 16'h200 + 16'(k);
         end
      end
      chk("B total accepts", k, 10);
      chk("B frame1 count", got_b.size(), 26);
      for (int i = 16; i < 26 && i < got_b.size(); i++)
         chk($sformatf("B frame1 data%0d", i - 16), got_b[i], 'h200 + i - 16);
      chk("B level drained", int'(lvl_b), 0);

`ifdef FRAME_CHECK_EN
      rst_a = 1'b1; @(posedge clk); #1;
      rst_a = 1'b0;
      chk("err after reset", int'(err_a), 0);
      for (int i = 0; i < 4; i++) begin
         va = 1'b1; da = 16'h10 + 16'(i); la = (i == 2);
         @(posedge clk); #1;
         chk($sformatf("err early last s%0d", i), int'(err_a), (i >= 2) ? 1 : 0);
      end
      va = 1'b0; la = 1'b0;
      repeat (3) @(posedge clk); #1;
      chk("err sticky", int'(err_a), 1);
      rst_a = 1'b1; @(posedge clk); #1;
      rst_a = 1'b0;
      for (int i = 0; i < 4; i++) begin
         va = 1'b1; da = 16'h20 + 16'(i); la = (i == 3);
         @(posedge clk); #1;
         chk($sformatf("err good frame s%0d", i), int'(err_a), 0);
      end
      va = 1'b0; la = 1'b0;
      repeat (2) @(posedge clk); #1;
      chk("err good frame end", int'(err_a), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
